// File: rtl/decade_ctrl_pkg.sv
// Shared encodings and BCD helpers for the decade chain run controller.
package decade_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/decade_digit.sv
// One BCD decade (0-9) with synchronous clear and ripple carry to the next digit.
module decade_digit
    import decade_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == BCD_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run controller for a cascaded BCD counter: start/pause/resume/clear FSM,
// count-rate prescaler, validated target register and completion compare.
module decade_chain_ctrl
    import decade_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  target_load,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  tick,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   target_q, target_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;
    logic            cfg_err_q, cfg_err_d;

    logic            inc0;
    logic            cnt_clr;
    logic [DIGITS-1:0] carry_w;
    logic [DIGITS:0] inc_chain;
    logic [CW-1:0]   cnt_next;
    logic            tgt_ok;

    // Kept out of the FSM block so the carry chain and compare do not loop back into it.
    assign inc0      = (state_q == ST_RUN) && !clear && !pause && (presc_q == PS_LAST);
    assign inc_chain = {carry_w, inc0};

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        decade_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (cnt_clr),
            .inc   (inc_chain[i]),
            .q     (count[4*i +: 4]),
            .carry (carry_w[i])
        );
    end

    // Value the digits will hold after this edge, used for the target compare.
    always_comb begin
        cnt_next = count;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (inc_chain[i]) begin
                cnt_next[4*i +: 4] = (count[4*i +: 4] == BCD_MAX) ? 4'd0 : count[4*i +: 4] + 4'd1;
            end
        end
        if (inc_chain[DIGITS]) begin
            cnt_next = '0;
        end
    end

    always_comb begin
        tgt_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(target[4*i +: 4])) begin
                tgt_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        target_d  = target_q;
        cnt_clr   = 1'b0;
        tick_d    = inc0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (inc0) begin
                        presc_d = '0;
                        if (cnt_next == target_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                        cnt_clr = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (target_load && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            if (tgt_ok) begin
                target_d = target;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            target_q  <= {DIGITS{BCD_MAX}};
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            target_q  <= target_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign state   = state_q;
    assign tick    = tick_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Directed bench: one 2-digit/PRESCALE=1 instance and one 3-digit/PRESCALE=4 instance.
module tb_decade_chain_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_clear, a_start, a_pause, a_tl;
    logic [7:0]  a_tgt, a_count;
    logic [1:0]  a_state;
    logic        a_tick, a_done, a_err;

    logic        b_clear, b_start, b_pause, b_tl;
    logic [11:0] b_tgt, b_count;
    logic [1:0]  b_state;
    logic        b_tick, b_done, b_err;

    decade_chain_ctrl #(.DIGITS(2), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .clear(a_clear), .start(a_start), .pause(a_pause),
        .target_load(a_tl), .target(a_tgt), .count(a_count), .state(a_state),
        .tick(a_tick), .done(a_done), .cfg_err(a_err)
    );

    decade_chain_ctrl #(.DIGITS(3), .PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .clear(b_clear), .start(b_start), .pause(b_pause),
        .target_load(b_tl), .target(b_tgt), .count(b_count), .state(b_state),
        .tick(b_tick), .done(b_done), .cfg_err(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] bcd(input int n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    initial begin
        int ticks;
        int n;
        int w;
        bit timed_out;

        rst = 1'b1;
        a_clear = 0; a_start = 0; a_pause = 0; a_tl = 0; a_tgt = '0;
        b_clear = 0; b_start = 0; b_pause = 0; b_tl = 0; b_tgt = '0;
        #12;
        chk("rst_a_count", a_count, 0);
        chk("rst_a_state", a_state, 0);
        chk("rst_a_tick",  a_tick, 0);
        chk("rst_a_done",  a_done, 0);
        chk("rst_a_err",   a_err, 0);
        chk("rst_b_count", b_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Test 1: target 12, one increment per cycle
        a_tgt = 8'h12; a_tl = 1; step(); a_tl = 0;
        chk("t1_load_err", a_err, 0);
        a_start = 1; step(); a_start = 0;
        chk("t1_run_state", a_state, 1);
        chk("t1_start_count", a_count, 0);
        chk("t1_start_tick", a_tick, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t1_count", a_count, bcd(k));
            chk("t1_tick", a_tick, 1);
            chk("t1_done", a_done, (k == 12));
        end
        chk("t1_state_done", a_state, 3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t1_hold_count", a_count, 12'h012);
            chk("t1_hold_tick", a_tick, 0);
            chk("t1_hold_done", a_done, 0);
            chk("t1_hold_state", a_state, 3);
        end

        // Test 5: bad load in DONE, ignored load in RUN, restart from DONE
        a_tgt = 8'h1A; a_tl = 1; step(); a_tl = 0;
        chk("t5_cfg_err", a_err, 1);
        step();
        chk("t5_cfg_err_pulse", a_err, 0);
        a_start = 1; step(); a_start = 0;
        chk("t5_restart_count", a_count, 0);
        chk("t5_restart_state", a_state, 1);
        a_tgt = 8'h05; a_tl = 1; step(); a_tl = 0;
        chk("t5_run_load_err", a_err, 0);
        chk("t5_count1", a_count, 1);
        for (int k = 2; k <= 12; k++) begin
            step();
            chk("t5_count", a_count, bcd(k));
            chk("t5_done", a_done, (k == 12));
        end
        chk("t5_state_done", a_state, 3);

        // Test 4: target 00 needs a full wrap
        a_tgt = 8'h00; a_tl = 1; step(); a_tl = 0;
        chk("t4_load_err", a_err, 0);
        a_start = 1; step(); a_start = 0;
        chk("t4_start_count", a_count, 0);
        chk("t4_start_state", a_state, 1);
        ticks = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (a_tick) ticks++;
            if (k < 100) begin
                chk("t4_count", a_count, bcd(k));
                chk("t4_done_early", a_done, 0);
            end else begin
                chk("t4_wrap_count", a_count, 0);
                chk("t4_done", a_done, 1);
            end
        end
        chk("t4_ticks", ticks, 100);
        chk("t4_state_done", a_state, 3);

        // Test 3: PRESCALE=4 pause/resume keeps prescaler phase
        b_tgt = 12'h100; b_tl = 1; step(); b_tl = 0;
        chk("t3_load_err", b_err, 0);
        b_start = 1; step(); b_start = 0;
        chk("t3_run_state", b_state, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_first_tick", b_tick, (k == 4));
            chk("t3_first_count", b_count, (k == 4) ? 1 : 0);
        end
        step(); step();
        b_pause = 1; step(); b_pause = 0;
        chk("t3_pause_state", b_state, 2);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t3_pause_count", b_count, 1);
            chk("t3_pause_tick", b_tick, 0);
            chk("t3_pause_state_hold", b_state, 2);
        end
        b_start = 1; step(); b_start = 0;
        chk("t3_resume_state", b_state, 1);
        chk("t3_resume_count", b_count, 1);
        step();
        chk("t3_resume_tick0", b_tick, 0);
        chk("t3_resume_count0", b_count, 1);
        step();
        chk("t3_resume_tick", b_tick, 1);
        chk("t3_resume_count2", b_count, 2);

        // Test 2: carries 009->010, 099->100, done at 100
        n = 2;
        timed_out = 1'b0;
        while (n < 100 && !timed_out) begin
            w = 0;
            do begin
                step();
                w++;
            end while (!b_tick && w < 8);
            if (!b_tick) begin
                chk("t2_tick_timeout", b_tick, 1);
                timed_out = 1'b1;
            end else begin
                n++;
                chk("t2_period", w, 4);
                chk("t2_count", b_count, bcd(n));
                chk("t2_done", b_done, (n == 100));
            end
        end
        chk("t2_state_done", b_state, 3);
        step();
        chk("t2_hold_count", b_count, 12'h100);
        chk("t2_done_pulse", b_done, 0);

        // Test 6: async reset mid-RUN, then clear+start in RUN
        a_start = 1; step(); a_start = 0;
        chk("t6_restart_count", a_count, 0);
        step(); step(); step();
        chk("t6_count3", a_count, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_count", a_count, 0);
        chk("t6_rst_state", a_state, 0);
        chk("t6_rst_tick", a_tick, 0);
        chk("t6_rst_done", a_done, 0);
        #2;
        rst = 1'b0;
        step();
        chk("t6_post_rst_state", a_state, 0);
        a_start = 1; step(); a_start = 0;
        step(); step();
        chk("t6_run_count", a_count, 2);
        chk("t6_run_state", a_state, 1);
        a_clear = 1; a_start = 1; step(); a_clear = 0; a_start = 0;
        chk("t6_clr_state", a_state, 0);
        chk("t6_clr_count", a_count, 0);
        chk("t6_clr_tick", a_tick, 0);
        step();
        chk("t6_idle_tick", a_tick, 0);
        chk("t6_idle_count", a_count, 0);
        chk("t6_idle_state", a_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
